// File: rtl/usb_tx.sv
// usb_tx: USB full-speed style packet transmitter.
//   Sends SYNC, then a PID (NAK/ACK) or a raw data payload, then EOP,
//   NRZI-encoded with bit stuffing. The bit clock is derived from clk
//   using a repeating 8/8/9 clk pattern.
// Ports:
//   clk                 in   system clock, rising edge
//   n_rst               in   synchronous active-high reset
//   tx_packet[1:0]      in   command: 00 none, 01 SEND_DATA, 10 NAK, 11 ACK
//   tx_packet_data[7:0] in   payload byte, captured while get_tx_packet_data=1
//   tx_packet_size[6:0] in   payload byte count, sampled with the command
//   dplus_out           out  D+ drive
//   dminus_out          out  D- drive
//   get_tx_packet_data  out  one-clk strobe requesting the next payload byte
module usb_tx (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] tx_packet,
  input  logic [7:0] tx_packet_data,
  input  logic [6:0] tx_packet_size,
  output logic       dplus_out,
  output logic       dminus_out,
  output logic       get_tx_packet_data
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PID,
    DATA,
    EOP_SE0,
    EOP_J
  } state_t;

  localparam logic [1:0] CMD_SEND = 2'b01;
  localparam logic [1:0] CMD_NAK  = 2'b10;
  localparam logic [1:0] CMD_ACK  = 2'b11;

  state_t     state;
  logic [1:0] cmd;
  logic [6:0] bytes_left;  // payload bytes not yet requested
  logic [7:0] shreg;       // byte currently being serialized
  logic [3:0] bit_idx;     // index of the next bit of shreg to send; 8 = byte done
  logic       have_byte;   // a fetched payload byte waits in shreg
  logic [2:0] ones;        // consecutive logical 1s on the line
  logic       lvl;         // NRZI history (current D+ level)
  logic [3:0] cnt;         // clk count within the current bit period
  logic [1:0] phase;       // position in the 8/8/9 pattern
  logic       eop_cnt;

  logic       period_end;
  logic       do_stuff;
  logic       exhausted;
  logic       pid_next;
  logic [7:0] next_byte;
  logic       more_byte;
  logic       data_bit;
  logic       tx_lvl;
  logic       fetch;

  always_comb begin
    period_end = (cnt == ((phase == 2'd2) ? 4'd8 : 4'd7));
    do_stuff   = (ones == 3'd6);
    exhausted  = bit_idx[3];
    pid_next   = (state == SYNC) && ((cmd == CMD_NAK) || (cmd == CMD_ACK));
    next_byte  = pid_next ? ((cmd == CMD_NAK) ? 8'hA5 : 8'h2D) : shreg;
    more_byte  = pid_next || have_byte;
    data_bit   = exhausted ? next_byte[0] : shreg[bit_idx[2:0]];
    // Logical 0 (real or stuffed) toggles the line, 1 holds it.
    tx_lvl     = (do_stuff || !data_bit) ? ~lvl : lvl;
    // Request the following payload byte while the last bit of the
    // current SYNC/data byte is on the line.
    fetch      = !exhausted && (bit_idx == 4'd7) &&
                 ((state == SYNC) || (state == DATA)) &&
                 (cmd == CMD_SEND) && (bytes_left != 7'd0);
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state              <= IDLE;
      cmd                <= 2'b00;
      bytes_left         <= 7'd0;
      bit_idx            <= 4'd0;
      have_byte          <= 1'b0;
      ones               <= 3'd0;
      lvl                <= 1'b1;
      cnt                <= 4'd0;
      phase              <= 2'd0;
      eop_cnt            <= 1'b0;
      dplus_out          <= 1'b1;
      dminus_out         <= 1'b0;
      get_tx_packet_data <= 1'b0;
    end else begin
      get_tx_packet_data <= 1'b0;

      if (get_tx_packet_data) begin
        shreg     <= tx_packet_data;
        have_byte <= 1'b1;
      end

      if (state != IDLE) begin
        if (period_end) begin
          cnt   <= 4'd0;
          phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end

      case (state)
        IDLE: begin
          if (tx_packet != 2'b00) begin
            // First SYNC bit (a 0) goes out immediately, toggling from J.
            state      <= SYNC;
            cmd        <= tx_packet;
            bytes_left <= (tx_packet == CMD_SEND) ? tx_packet_size : 7'd0;
            shreg      <= 8'h80;
            bit_idx    <= 4'd1;
            have_byte  <= 1'b0;
            ones       <= 3'd0;
            lvl        <= 1'b0;
            cnt        <= 4'd0;
            phase      <= 2'd0;
            dplus_out  <= 1'b0;
            dminus_out <= 1'b1;
          end
        end

        SYNC, PID, DATA: begin
          if (period_end) begin
            if (do_stuff) begin
              ones       <= 3'd0;
              lvl        <= tx_lvl;
              dplus_out  <= tx_lvl;
              dminus_out <= ~tx_lvl;
            end else if (!exhausted || more_byte) begin
              ones       <= data_bit ? ones + 3'd1 : 3'd0;
              lvl        <= tx_lvl;
              dplus_out  <= tx_lvl;
              dminus_out <= ~tx_lvl;
              if (exhausted) begin
                shreg     <= next_byte;
                bit_idx   <= 4'd1;
                have_byte <= 1'b0;
                state     <= pid_next ? PID : DATA;
              end else begin
                bit_idx <= bit_idx + 4'd1;
              end
              if (fetch) begin
                get_tx_packet_data <= 1'b1;
                bytes_left         <= bytes_left - 7'd1;
              end
            end else begin
              state      <= EOP_SE0;
              eop_cnt    <= 1'b0;
              dplus_out  <= 1'b0;
              dminus_out <= 1'b0;
            end
          end
        end

        EOP_SE0: begin
          if (period_end) begin
            if (!eop_cnt) begin
              eop_cnt <= 1'b1;
            end else begin
              state      <= EOP_J;
              dplus_out  <= 1'b1;
              dminus_out <= 1'b0;
            end
          end
        end

        EOP_J: begin
          if (period_end) begin
            state <= IDLE;
            lvl   <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx.sv
module tb_usb_tx;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [1:0] tx_packet;
  logic [7:0] tx_packet_data;
  logic [6:0] tx_packet_size;
  logic       dplus_out;
  logic       dminus_out;
  logic       get_tx_packet_data;

  usb_tx dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_packet          (tx_packet),
    .tx_packet_data     (tx_packet_data),
    .tx_packet_size     (tx_packet_size),
    .dplus_out          (dplus_out),
    .dminus_out         (dminus_out),
    .get_tx_packet_data (get_tx_packet_data)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] sbq[$];          // expected {dplus, dminus, get} per clk
  logic [7:0] data_bytes[4];
  int         exp_gets;

  task automatic check(input string tag, input int cyc, input logic [2:0] obs,
                       input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc %0d observed {dp,dm,get}=%b expected %b", tag, cyc, obs, exp);
    end
  endtask

  // Bit-level reference: logical bits -> stuffing -> NRZI -> 8/8/9 timing.
  task automatic build(input logic [1:0] cmd, input int size);
    logic       lb[$];
    logic       lg[$];
    logic       sb[$];
    logic       sg[$];
    logic [7:0] syncb = 8'h80;
    logic [7:0] byt;
    int         nbytes;
    int         ones;
    int         k;
    int         per;
    logic       lv;
    sbq.delete();
    exp_gets = 0;
    for (int i = 0; i < 8; i++) begin
      lb.push_back(syncb[i]);
      lg.push_back((i == 7) && (cmd == 2'b01) && (size > 0));
    end
    nbytes = (cmd == 2'b01) ? size : 1;
    for (int j = 0; j < nbytes; j++) begin
      byt = (cmd == 2'b10) ? 8'hA5 : (cmd == 2'b11) ? 8'h2D : data_bytes[j];
      for (int i = 0; i < 8; i++) begin
        lb.push_back(byt[i]);
        lg.push_back((i == 7) && (cmd == 2'b01) && (j + 1 < size));
      end
    end
    ones = 0;
    foreach (lb[i]) begin
      sb.push_back(lb[i]);
      sg.push_back(lg[i]);
      if (lg[i]) exp_gets++;
      ones = lb[i] ? ones + 1 : 0;
      if (ones == 6) begin
        sb.push_back(1'b0);
        sg.push_back(1'b0);
        ones = 0;
      end
    end
    lv = 1'b1;
    k  = 0;
    foreach (sb[i]) begin
      if (!sb[i]) lv = ~lv;
      per = (k % 3 == 2) ? 9 : 8;
      for (int c = 0; c < per; c++) sbq.push_back({lv, ~lv, (c == 0) && sg[i]});
      k++;
    end
    for (int e = 0; e < 3; e++) begin
      per = (k % 3 == 2) ? 9 : 8;
      for (int c = 0; c < per; c++) sbq.push_back((e < 2) ? 3'b000 : 3'b100);
      k++;
    end
    for (int c = 0; c < 4; c++) sbq.push_back(3'b100);
  endtask

  task automatic run(input string tag, input logic [1:0] cmd, input logic [6:0] size,
                     input int inject_at, input int abort_at);
    int         cyc;
    int         fidx;
    int         gets;
    logic       pend;
    logic [2:0] exp;
    build(cmd, int'(size));
    fidx = 0;
    gets = 0;
    pend = 1'b0;
    tx_packet_data = data_bytes[0];
    @(negedge clk);
    tx_packet      = cmd;
    tx_packet_size = size;
    @(negedge clk);
    tx_packet      = 2'b00;
    tx_packet_size = 7'h55;
    cyc = 0;
    while (sbq.size() > 0) begin
      if (pend) begin
        fidx++;
        tx_packet_data = (fidx < 4) ? data_bytes[fidx] : 8'hC3;
        pend = 1'b0;
      end
      if (cyc == abort_at) begin
        sbq.delete();
        n_rst = 1'b1;
        @(negedge clk);
        check({tag, "_rst"}, cyc, {dplus_out, dminus_out, get_tx_packet_data}, 3'b100);
        n_rst = 1'b0;
        @(negedge clk);
        check({tag, "_rst_idle"}, cyc + 1, {dplus_out, dminus_out, get_tx_packet_data}, 3'b100);
        return;
      end
      exp = sbq.pop_front();
      check(tag, cyc, {dplus_out, dminus_out, get_tx_packet_data}, exp);
      if (get_tx_packet_data) begin
        pend = 1'b1;
        gets++;
      end
      tx_packet = (cyc == inject_at) ? 2'b01 : 2'b00;
      cyc++;
      @(negedge clk);
    end
    tx_packet = 2'b00;
    checks++;
    assert (gets == exp_gets) else begin
      errors++;
      $error("FAIL %s_gets observed %0d expected %0d", tag, gets, exp_gets);
    end
  endtask

  initial begin
    n_rst          = 1'b1;
    tx_packet      = 2'b00;
    tx_packet_data = 8'h00;
    tx_packet_size = 7'd0;
    data_bytes[0]  = 8'h00;
    data_bytes[1]  = 8'h00;
    data_bytes[2]  = 8'h00;
    data_bytes[3]  = 8'h00;
    repeat (2) @(negedge clk);
    check("reset", 0, {dplus_out, dminus_out, get_tx_packet_data}, 3'b100);
    n_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle", i, {dplus_out, dminus_out, get_tx_packet_data}, 3'b100);
    end

    run("nak", 2'b10, 7'd0, -1, -1);
    run("ack", 2'b11, 7'd0, 100, -1);

    data_bytes[0] = 8'hF0;
    data_bytes[1] = 8'h0F;
    run("data2", 2'b01, 7'd2, -1, -1);

    data_bytes[0] = 8'hFE;
    run("data1_stuff", 2'b01, 7'd1, -1, -1);

    run("data0", 2'b01, 7'd0, -1, -1);

    data_bytes[0] = 8'h3C;
    data_bytes[1] = 8'hFF;
    data_bytes[2] = 8'h81;
    run("data3", 2'b01, 7'd3, -1, -1);

    run("nak_abort", 2'b10, 7'd0, -1, 80);
    run("ack_after_rst", 2'b11, 7'd0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
